// File: rtl/alarm_led_bank.sv
// rtl/alarm_led_bank.sv - Avalon-MM WIDTH-bit LED bank with per-channel blink and set/clear registers
// Optional PWM dimming (DUTY register, address 6) is enabled by defining ALARM_LED_BANK_PWM_EN.
module alarm_led_bank #(
  parameter int WIDTH = 8,
  parameter int PERIOD_W = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_DUTY   = 3'd6;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mode_q, mode_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                wr_en;
  logic [32:0]         status_w;

`ifdef ALARM_LED_BANK_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
`endif

  assign wr_en    = chipselect & ~write_n;
  assign status_w = 33'({cnt_q, phase_q});
  assign out_port = out_q;

  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
`ifdef ALARM_LED_BANK_PWM_EN
    duty_d   = duty_q;
`endif
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d   = writedata[WIDTH-1:0];
        ADDR_MODE:   mode_d   = writedata[WIDTH-1:0];
        ADDR_PERIOD: period_d = writedata[PERIOD_W-1:0];
        ADDR_OUTSET: data_d   = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLR: data_d   = data_q & ~writedata[WIDTH-1:0];
`ifdef ALARM_LED_BANK_PWM_EN
        ADDR_DUTY:   duty_d   = writedata[7:0];
`endif
        default: ;
      endcase
    end
  end

  // A PERIOD write restarts the half-period in the lit phase, overriding any terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && (address == ADDR_PERIOD)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == (period_q - PERIOD_W'(1))) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_W'(1);
    end
  end

  always_comb begin
    out_d = data_q & (~mode_q | {WIDTH{phase_q}});
`ifdef ALARM_LED_BANK_PWM_EN
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    if (!((pwm_cnt_q < duty_q) || (duty_q == 8'hFF))) begin
      out_d = '0;
    end
`endif
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]    = data_q;
      ADDR_MODE:   readdata[WIDTH-1:0]    = mode_q;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: readdata               = status_w[31:0];
`ifdef ALARM_LED_BANK_PWM_EN
      ADDR_DUTY:   readdata[7:0]          = duty_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= RESET_VALUE;
      mode_q    <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b1;
      out_q     <= '0;
`ifdef ALARM_LED_BANK_PWM_EN
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'd0;
`endif
    end else begin
      data_q    <= data_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      out_q     <= out_d;
`ifdef ALARM_LED_BANK_PWM_EN
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_led_bank.sv
// tb/tb_alarm_led_bank.sv - scoreboard bench for alarm_led_bank against a cycle-count reference model
// Honours ALARM_LED_BANK_PWM_EN when the design is built with it.
module tb_alarm_led_bank;

  localparam int WIDTH = 8;
  localparam int PERIOD_W = 24;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h5A;
  localparam longint WMASK = (64'd1 << WIDTH) - 1;
  localparam longint PMASK = (64'd1 << PERIOD_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  out_port;

  always #5 clk = ~clk;

  alarm_led_bank #(
    .WIDTH(WIDTH),
    .PERIOD_W(PERIOD_W),
    .RESET_VALUE(RST_VAL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  typedef struct {
    logic [WIDTH-1:0] exp_out;
    bit               chk_rd;
    logic [31:0]      exp_rd;
    string            tag;
  } item_t;

  item_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model state: register contents plus the cycle at which the blink timer last restarted.
  longint m_data, m_mode, m_period, m_duty;
  longint k, m_t0, m_pwm_base;
  bit     m_rst;
  logic [WIDTH-1:0] exp_out_cur;

  function automatic longint m_cnt();
    if (m_period == 0) return 0;
    return (k - m_t0) % m_period;
  endfunction

  function automatic bit m_phase();
    if (m_period == 0) return 1'b1;
    return (((k - m_t0) / m_period) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_mode);
      3'd2: return 32'(m_period);
      3'd5: return 32'((m_cnt() * 2) + (m_phase() ? 1 : 0));
`ifdef ALARM_LED_BANK_PWM_EN
      3'd6: return 32'(m_duty);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] m_out();
    longint v;
`ifdef ALARM_LED_BANK_PWM_EN
    longint pwm;
`endif
    if (m_rst) return '0;
    v = m_phase() ? m_data : (m_data & ~m_mode);
    v = v & WMASK;
`ifdef ALARM_LED_BANK_PWM_EN
    pwm = (k - m_pwm_base) % 256;
    if (!((pwm < m_duty) || (m_duty == 255))) v = 0;
`endif
    return WIDTH'(v);
  endfunction

  function automatic void m_write(input logic [2:0] a, input logic [31:0] wd);
    longint w;
    w = longint'(wd);
    if (m_rst) return;
    case (a)
      3'd0: m_data = w & WMASK;
      3'd1: m_mode = w & WMASK;
      3'd2: begin
        m_period = w & PMASK;
        m_t0 = k + 1;
      end
      3'd3: m_data = (m_data | w) & WMASK;
      3'd4: m_data = m_data & ~w & WMASK;
`ifdef ALARM_LED_BANK_PWM_EN
      3'd6: m_duty = w & 255;
`endif
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_data = longint'(RST_VAL);
    m_mode = 0;
    m_period = 0;
    m_duty = 255;
    m_rst = 1'b1;
  endfunction

  // One bus cycle, driven just after a rising edge; queues what the monitor must see this cycle.
  task automatic step(input bit rst_in, input bit wr, input bit rd,
                      input logic [2:0] a, input logic [31:0] wd, input string tag);
    item_t it;
    if (!rst_in && !m_rst) begin
      model_reset();
      exp_out_cur = '0;
    end
    if (rst_in && m_rst) begin
      m_rst = 1'b0;
      m_pwm_base = k;
    end
    reset_n    = rst_in;
    chipselect = wr | rd;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    it.exp_out = exp_out_cur;
    it.chk_rd  = rd;
    it.exp_rd  = m_read(a);
    it.tag     = tag;
    exp_q.push_back(it);
    exp_out_cur = m_out();
    if (wr) m_write(a, wd);
    k++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    item_t it;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      n_cmp++;
      if (out_port !== it.exp_out) begin
        n_bad++;
        $display("FAIL %s out_port: got %h expected %h (t=%0t)", it.tag, out_port, it.exp_out, $time);
      end
      if (it.chk_rd) begin
        n_cmp++;
        if (readdata !== it.exp_rd) begin
          n_bad++;
          $display("FAIL %s readdata[a=%0d]: got %h expected %h (t=%0t)",
                   it.tag, address, readdata, it.exp_rd, $time);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [2:0]  ra;
    logic [31:0] rw;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 3'd0;
    writedata = 32'd0;
    model_reset();
    k = 0;
    m_t0 = 0;
    m_pwm_base = 0;
    exp_out_cur = '0;
    @(posedge clk);
    #1;

    for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 1'b1, 3'(a), 32'd0, "reset_read");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "release");
    for (int a = 0; a < 7; a++) step(1'b1, 1'b0, 1'b1, 3'(a), 32'd0, "post_reset");

    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_00A5, "wr_data");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "rd_data");
    step(1'b1, 1'b1, 1'b0, 3'd3, 32'hFFFF_FF0F, "outset");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "rd_outset");
    step(1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_0081, "outclear");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "rd_outclear");
    step(1'b1, 1'b0, 1'b1, 3'd3, 32'd0, "rd_outset_wo");

    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_00FF, "blink_setup");
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_000F, "blink_setup");
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'd4, "blink_setup");
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b1, 3'd5, 32'd0, "blink4");

    guard = 0;
    while (!(m_phase() == 1'b0 && m_cnt() == 2) && guard < 50) begin
      step(1'b1, 1'b0, 1'b1, 3'd5, 32'd0, "seek_mid");
      guard++;
    end
    if (guard >= 50) begin
      n_bad++;
      $display("FAIL seek_mid: model never reached phase 0 count 2 within %0d cycles", guard);
    end
    step(1'b1, 1'b1, 1'b1, 3'd2, 32'd10, "reperiod");
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b1, 3'd5, 32'd0, "blink10");

    step(1'b1, 1'b1, 1'b0, 3'd2, 32'd0, "steady_setup");
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_00FF, "steady_setup");
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_003C, "steady_setup");
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1, 3'd5, 32'd0, "steady");

    step(1'b1, 1'b1, 1'b0, 3'd2, 32'd3, "async_setup");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 3'd5, 32'd0, "pre_async");
    step(1'b0, 1'b0, 1'b1, 3'd5, 32'd0, "async_reset");
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'h0000_00FF, "wr_in_reset");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "async_release");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "async_release");

    step(1'b1, 1'b1, 1'b0, 3'd6, 32'h0000_0040, "wr_addr6");
    step(1'b1, 1'b0, 1'b1, 3'd6, 32'd0, "rd_addr6");
    step(1'b1, 1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, "wr_addr7");
    step(1'b1, 1'b0, 1'b1, 3'd7, 32'd0, "rd_addr7");

`ifdef ALARM_LED_BANK_PWM_EN
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'd0, "pwm_setup");
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0001, "pwm_setup");
    step(1'b1, 1'b1, 1'b0, 3'd6, 32'd64, "pwm_setup");
    for (int i = 0; i < 520; i++) step(1'b1, 1'b0, 1'b1, 3'd6, 32'd0, "pwm64");
    step(1'b1, 1'b1, 1'b0, 3'd6, 32'd0, "pwm_off");
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, "pwm0");
    step(1'b1, 1'b1, 1'b0, 3'd6, 32'hFF, "pwm_full");
`endif

    for (int i = 0; i < 3000; i++) begin
      ra = 3'($urandom_range(0, 7));
      rw = $urandom;
      if (ra == 3'd2) rw = 32'($urandom_range(0, 6));
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0), 1'b1, ra, rw, "random");
    end

    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, "drain");
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, "drain");
    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_led_bank.md
Name: alarm_led_bank

Overview:
- Parametrised successor to the single-bit LED output port: an Avalon-MM slave driving a WIDTH-bit LED bank.
- Per-channel steady/blink mode, a programmable blink half-period timer, and atomic set/clear write registers.
- Sits on the alarm SoC's on-chip bus. The CPU uses it to flash alarm indicators without software polling.

Parameters:
- WIDTH, 8, number of LED channels (1..32).
- PERIOD_W, 24, width of the blink half-period register and counter (1..32).
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above the register width are ignored.
- readdata  output  32  read data; combinational from address, zero wait states, unused bits 0.
- out_port  output  WIDTH  registered LED drive.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on reset_n. All state is reset asynchronously.
- Reset values:
  - DATA = RESET_VALUE
  - MODE = 0
  - PERIOD = 0
  - blink counter = 0
  - phase = 1
  - out_port = 0
- A write occurs on a clk edge when chipselect=1, write_n=0. Writes to unmapped addresses are ignored. Reads of unmapped or write-only addresses return 0.
- Register map:
  - 0 DATA (RW): LED enable bits.
  - 1 MODE (RW): per-channel; 0 = steady, 1 = blink.
  - 2 PERIOD (RW): blink half-period in clk cycles, PERIOD_W bits.
  - 3 OUTSET (WO): DATA <= DATA | writedata[WIDTH-1:0].
  - 4 OUTCLEAR (WO): DATA <= DATA & ~writedata[WIDTH-1:0].
  - 5 STATUS (RO): bit0 = phase; bits[PERIOD_W:1] = current counter value.
- Blink timer:
  - If PERIOD == 0: counter held at 0, phase held at 1, so blink channels act as steady.
  - Else: counter increments each clk. When counter == PERIOD-1, counter <= 0 and phase toggles.
  - Half-period is exactly PERIOD cycles.
- A write to PERIOD, on the same edge, loads the new value, clears the counter to 0 and sets phase to 1. The write takes priority over the terminal-count toggle.
- A PERIOD value larger than the counter can reach is not possible: both are PERIOD_W bits wide.
- Output equation: out_port <= DATA & (~MODE | {WIDTH{phase}}), registered.
  - Latency: a DATA/MODE/OUTSET/OUTCLEAR write on edge N is visible on out_port after edge N+1.
  - A phase toggle on edge N is visible on out_port after edge N+1.
- readdata is pure combinational from address and the current register values. There is no read side effect.
- Reset asserted mid-blink: counter, phase and out_port return to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: ALARM_LED_BANK_PWM_EN.
- When defined:
  - Adds DUTY (RW, address 6, 8 bits, reset 8'hFF).
  - Adds a free-running 8-bit pwm_cnt (reset 0, increments every clk, wraps 255->0).
  - Output term becomes: DATA & (~MODE | {WIDTH{phase}}) & {WIDTH{(pwm_cnt < DUTY) | (DUTY == 8'hFF)}}.
  - DUTY=0 gives the LEDs fully off. DUTY=8'hFF gives the LEDs fully on.
- When undefined:
  - Address 6 reads 0 and writes are ignored.
  - No pwm_cnt exists. Output is as in Behaviour.

Test Plan:
- Reset, then read addresses 0-6 → DATA=RESET_VALUE, all others 0 except STATUS bit0=1; out_port=0 during reset, and out_port=RESET_VALUE one edge after reset release.
- Write DATA=8'hA5, then OUTSET 8'h0F, then OUTCLEAR 8'h81 → DATA reads 8'hA5, 8'hAF, 8'h2E in turn; out_port follows one cycle after each write.
- DATA=8'hFF, MODE=8'h0F, PERIOD=4 → out_port alternates 8'hFF/8'hF0 every 4 clk cycles; high nibble is never 0.
- Mid-blink (phase=0, counter=2), write PERIOD=10 → after the write edge STATUS shows counter=0, phase=1; next toggle occurs exactly 10 cycles later.
- PERIOD=0 with MODE=8'hFF, DATA=8'h3C → out_port steady 8'h3C for 100 cycles; assert reset_n low between clk edges → out_port 0 immediately.
- With ALARM_LED_BANK_PWM_EN: DATA=8'h01, MODE=0, DUTY=64 → bit0 high for exactly 64 of every 256 cycles. DUTY=0 → always 0. Without the macro, a write to address 6 reads back 0.
